// File: rtl/alu_pkg.sv
// Shared types for the ALU execute stage: opcodes, stage FSM states, flag bundle.
// Optional feature macro used by the stage files: ALU_EXEC_OVERFLOW_EN.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } exec_state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
  } alu_flags_t;

  // True for the opcodes that go through the adder and so own a carry.
  function automatic logic is_arith(input alu_op_e op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_datapath.sv
// Combinational ALU datapath: ADD/SUB share one adder (SUB = a + ~b + 1),
// AND/OR are bitwise. carry is the raw adder carry-out.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  alu_op_e      op,
  output logic [N-1:0] result,
  output logic         carry
);

  logic         is_sub;
  logic [N-1:0] b_eff;
  logic [N:0]   sum;

  assign is_sub = (op == ALU_SUB);
  assign b_eff  = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};

  // Select the operation result; every output gets a default first.
  always_comb begin
    // NOTE: assigning defaults at the top of always_comb guarantees no latch is inferred.
    result = sum[N-1:0];
    carry  = sum[N];
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = sum[N-1:0];
    endcase
  end

endmodule

// File: rtl/alu_flags.sv
// Combinational status-flag generation from one cycle's ALU result.
// Signed overflow is only produced when ALU_EXEC_OVERFLOW_EN is defined.
module alu_flags
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] result,
  input  logic         carry,
  input  alu_op_e      op,
  output alu_flags_t   flags
);

`ifdef ALU_EXEC_OVERFLOW_EN
  logic ovf;

  // Signed overflow: operands' effective signs agree but the result sign differs.
  always_comb begin
    ovf = 1'b0;
    case (op)
      ALU_ADD: ovf = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]);
      ALU_SUB: ovf = (a[N-1] != b[N-1]) && (result[N-1] != a[N-1]);
      default: ovf = 1'b0;
    endcase
  end
`else
  logic ovf;
  logic operands_unused;

  assign ovf             = 1'b0;
  assign operands_unused = ^{a, b};
`endif

  assign flags.carry    = is_arith(op) ? carry : 1'b0;
  assign flags.zero     = (result == '0);
  assign flags.negative = result[N-1];
  assign flags.overflow = ovf;

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a 2-entry (OUT + SKID) elastic buffer.
// o_ready is a flop so it never depends combinationally on i_ready.
// Optional macro ALU_EXEC_OVERFLOW_EN adds per-bundle signed-overflow storage.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [1:0]   i_alu_ctrl,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [N-1:0] o_result,
  output logic         o_carry,
  output logic         o_zero,
  output logic         o_negative,
  output logic         o_overflow,
  output logic         o_valid,
  input  logic         i_ready
);

  alu_op_e     op;
  logic [N-1:0] calc_result;
  logic        calc_carry;
  alu_flags_t  calc_flags;

  exec_state_e state, state_next;
  logic        ready_q;
  logic        accept, deliver;
  logic        load_out_new, load_out_skid, load_skid;

  logic [N-1:0] out_result, skid_result;
  logic         out_carry, out_zero, out_negative;
  logic         skid_carry, skid_zero, skid_negative;

  assign op = alu_op_e'(i_alu_ctrl);

  alu_datapath #(.N(N)) u_datapath (
    .a      (i_a),
    .b      (i_b),
    .op     (op),
    .result (calc_result),
    .carry  (calc_carry)
  );

  alu_flags #(.N(N)) u_flags (
    .a      (i_a),
    .b      (i_b),
    .result (calc_result),
    .carry  (calc_carry),
    .op     (op),
    .flags  (calc_flags)
  );

  assign accept  = i_valid && ready_q;
  assign deliver = (state != ST_EMPTY) && i_ready;

  // Next-state and buffer-load decode for the OUT/SKID occupancy FSM.
  always_comb begin
    state_next    = state;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_next   = ST_ONE;
          load_out_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && deliver) begin
          load_out_new = 1'b1;
        end else if (accept) begin
          state_next = ST_TWO;
          load_skid  = 1'b1;
        end else if (deliver) begin
          state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // ready_q is low in TWO, so no accept can arrive here.
        if (deliver) begin
          state_next    = ST_ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // State register plus registered ready derived from the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (i_rst) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_next;
      ready_q <= (state_next != ST_TWO);
    end
  end

  // OUT register: visible bundle, cleared on reset so outputs read as zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_result   <= '0;
      out_carry    <= 1'b0;
      out_zero     <= 1'b0;
      out_negative <= 1'b0;
    end else if (load_out_new) begin
      out_result   <= calc_result;
      out_carry    <= calc_flags.carry;
      out_zero     <= calc_flags.zero;
      out_negative <= calc_flags.negative;
    end else if (load_out_skid) begin
      out_result   <= skid_result;
      out_carry    <= skid_carry;
      out_zero     <= skid_zero;
      out_negative <= skid_negative;
    end
  end

  // SKID register: captures the bundle accepted while OUT is stalled.
  always_ff @(posedge i_clk) begin
    // NOTE: SKID holds data only; its validity lives in the FSM state, so it needs no reset.
    if (load_skid) begin
      skid_result   <= calc_result;
      skid_carry    <= calc_flags.carry;
      skid_zero     <= calc_flags.zero;
      skid_negative <= calc_flags.negative;
    end
  end

`ifdef ALU_EXEC_OVERFLOW_EN
  logic out_overflow, skid_overflow;

  // Overflow bit of the OUT register, moved in lockstep with the result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_overflow <= 1'b0;
    end else if (load_out_new) begin
      out_overflow <= calc_flags.overflow;
    end else if (load_out_skid) begin
      out_overflow <= skid_overflow;
    end
  end

  // Overflow bit of the SKID register.
  always_ff @(posedge i_clk) begin
    if (load_skid) begin
      skid_overflow <= calc_flags.overflow;
    end
  end

  assign o_overflow = out_overflow;
`else
  logic overflow_unused;

  assign overflow_unused = calc_flags.overflow;
  assign o_overflow      = 1'b0;
`endif

  assign o_ready    = ready_q;
  assign o_valid    = (state != ST_EMPTY);
  assign o_result   = out_result;
  assign o_carry    = out_carry;
  assign o_zero     = out_zero;
  assign o_negative = out_negative;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: an 8-bit and a 64-bit instance.
// Expected bundles are pushed when the stimulus is accepted; monitors pop and
// compare on every delivery. Honours ALU_EXEC_OVERFLOW_EN for overflow values.
module tb_alu_exec_stage;
  import alu_pkg::*;

  typedef struct {
    logic [63:0] result;
    logic        carry;
    logic        zero;
    logic        negative;
    logic        overflow;
  } exp_t;

`ifdef ALU_EXEC_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic [7:0] a8, b8, res8;
  logic [1:0] ctrl8;
  logic       valid8 = 1'b0, iready8 = 1'b1;
  logic       rdy8, ovalid8, c8, z8, n8, o8;

  // 64-bit instance
  logic [63:0] a64, b64, res64;
  logic [1:0]  ctrl64;
  logic        valid64 = 1'b0, iready64 = 1'b1;
  logic        rdy64, ovalid64, c64, z64, n64, o64;

  exp_t q8[$];
  exp_t q64[$];
  exp_t e8, e64;
  int   errors = 0;
  int   checks = 0;

  alu_exec_stage #(.N(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_a(a8), .i_b(b8), .i_alu_ctrl(ctrl8),
    .i_valid(valid8), .o_ready(rdy8), .o_result(res8), .o_carry(c8),
    .o_zero(z8), .o_negative(n8), .o_overflow(o8), .o_valid(ovalid8),
    .i_ready(iready8)
  );

  alu_exec_stage #(.N(64)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_a(a64), .i_b(b64), .i_alu_ctrl(ctrl64),
    .i_valid(valid64), .o_ready(rdy64), .o_result(res64), .o_carry(c64),
    .o_zero(z64), .o_negative(n64), .o_overflow(o64), .o_valid(ovalid64),
    .i_ready(iready64)
  );

  task automatic check(input string name, input logic [127:0] actual,
                       input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] r, input logic c, input logic z,
                              input logic n, input logic o);
    exp_t e;
    e.result = r; e.carry = c; e.zero = z; e.negative = n; e.overflow = o;
    return e;
  endfunction

  // Monitors: a delivery happens on the next rising edge when o_valid & i_ready.
  always @(negedge clk) begin
    if (!rst && ovalid8 && iready8) begin
      if (q8.size() == 0) begin
        check("dut8 unexpected output", 1, 0);
      end else begin
        e8 = q8.pop_front();
        check("dut8 bundle {result,c,z,n,v}", {res8, c8, z8, n8, o8},
              {e8.result[7:0], e8.carry, e8.zero, e8.negative, e8.overflow});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ovalid64 && iready64) begin
      if (q64.size() == 0) begin
        check("dut64 unexpected output", 1, 0);
      end else begin
        e64 = q64.pop_front();
        check("dut64 bundle {result,c,z,n,v}", {res64, c64, z64, n64, o64},
              {e64.result, e64.carry, e64.zero, e64.negative, e64.overflow});
      end
    end
  end

  // Present a bundle, wait (bounded) for acceptance, push expectation.
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b,
                       input alu_op_e op, input exp_t e);
    int n = 0;
    a8 = a; b8 = b; ctrl8 = op; valid8 = 1'b1;
    @(negedge clk);
    while (!rdy8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy8) check("dut8 accept timeout", 0, 1);
    else q8.push_back(e);
    @(posedge clk);
    #1;
    valid8 = 1'b0; a8 = 'x; b8 = 'x;
  endtask

  task automatic send64(input logic [63:0] a, input logic [63:0] b,
                        input alu_op_e op, input exp_t e);
    int n = 0;
    a64 = a; b64 = b; ctrl64 = op; valid64 = 1'b1;
    @(negedge clk);
    while (!rdy64 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy64) check("dut64 accept timeout", 0, 1);
    else q64.push_back(e);
    @(posedge clk);
    #1;
    valid64 = 1'b0; a64 = 'x; b64 = 'x;
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q8.size() != 0) check("dut8 drain timeout", 0, 1);
    #1;
  endtask

  task automatic drain64();
    int n = 0;
    while (q64.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q64.size() != 0) check("dut64 drain timeout", 0, 1);
    #1;
  endtask

  initial begin
    a8 = 'x; b8 = 'x; ctrl8 = 2'b00;
    a64 = 'x; b64 = 'x; ctrl64 = 2'b00;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("reset dut8 valid/ready", {ovalid8, rdy8}, 2'b01);
    check("reset dut8 outputs", {res8, c8, z8, n8, o8}, '0);
    check("reset dut64 valid/ready", {ovalid64, rdy64}, 2'b01);
    check("reset dut64 outputs", {res64, c64, z64, n64, o64}, '0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // ADD wraps to zero with carry; one-cycle latency
    send8(8'hFF, 8'h01, ALU_ADD, mk(64'h00, 1'b1, 1'b1, 1'b0, 1'b0));
    check("latency o_valid after accept", ovalid8, 1'b1);
    check("latency o_result after accept", res8, 8'h00);

    // SUB crossing the signed boundary
    send8(8'h80, 8'h01, ALU_SUB, mk(64'h7F, 1'b1, 1'b0, 1'b0, OVF_EN));

    // Back-to-back logic ops at full throughput
    send8(8'hF0, 8'h3C, ALU_AND, mk(64'h30, 1'b0, 1'b0, 1'b0, 1'b0));
    check("o_ready after AND", rdy8, 1'b1);
    send8(8'hF0, 8'h0C, ALU_OR, mk(64'hFC, 1'b0, 1'b0, 1'b1, 1'b0));
    check("o_ready after OR", rdy8, 1'b1);
    drain8();

    // Backpressure: two accepted, third held off
    iready8 = 1'b0;
    send8(8'd1, 8'd2, ALU_ADD, mk(64'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    send8(8'd3, 8'd4, ALU_ADD, mk(64'd7, 1'b0, 1'b0, 1'b0, 1'b0));
    a8 = 8'd5; b8 = 8'd6; ctrl8 = ALU_ADD; valid8 = 1'b1;
    @(negedge clk);
    check("backpressure o_ready", rdy8, 1'b0);
    check("backpressure o_valid", ovalid8, 1'b1);
    check("stalled o_result stable", res8, 8'd3);
    @(posedge clk);
    #1;
    iready8 = 1'b1;
    send8(8'd5, 8'd6, ALU_ADD, mk(64'd11, 1'b0, 1'b0, 1'b0, 1'b0));
    drain8();

    // 64-bit SUB with borrow
    send64(64'h0, 64'h1, ALU_SUB,
           mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0));
    drain64();

    // Asynchronous reset while both entries are full
    iready8 = 1'b0;
    send8(8'd10, 8'd20, ALU_ADD, mk(64'd30, 1'b0, 1'b0, 1'b0, 1'b0));
    send8(8'd1, 8'd1, ALU_ADD, mk(64'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    check("full before reset o_ready", rdy8, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async reset valid/ready", {ovalid8, rdy8}, 2'b01);
    check("async reset outputs", {res8, c8, z8, n8, o8}, '0);
    q8.delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    iready8 = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset o_valid", ovalid8, 1'b0);
    send8(8'd2, 8'd2, ALU_ADD, mk(64'd4, 1'b0, 1'b0, 1'b0, 1'b0));
    drain8();
    repeat (5) @(posedge clk);
    #1;
    check("no stale bundles", ovalid8, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Registered execute stage wrapped around the combinational ALU datapath (ADD/SUB/AND/OR, 2-bit control).
- Accepts operand/opcode bundles over a valid/ready handshake and computes the result.
- Registers result plus status flags (carry, zero, negative, overflow) for the downstream writeback/flags consumer.
- A 2-entry skid buffer keeps o_ready a pure register output at full throughput.

Parameters:
N, 64, operand/result width in bits (N >= 2)

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  asynchronous active-high reset
i_a  input  N  operand A
i_b  input  N  operand B
i_alu_ctrl  input  2  00 ADD, 01 SUB, 10 AND, 11 OR
i_valid  input  1  upstream bundle valid
o_ready  output  1  stage can accept a bundle
o_result  output  N  registered result
o_carry  output  1  adder carry-out; ADD/SUB only
o_zero  output  1  o_result == 0
o_negative  output  1  o_result[N-1]
o_overflow  output  1  signed overflow (see Optional Feature)
o_valid  output  1  output bundle valid
i_ready  input  1  downstream accepts bundle

Behaviour:
- Clock/reset: one clock i_clk; reset i_rst is asynchronous, active-high.
- Compute:
  - ADD: a+b, carry-in 0.
  - SUB: a+~b+1, carry-in 1; o_carry=1 means no borrow (a >= b unsigned).
  - Adder sum truncated to N bits.
  - AND/OR: bitwise; o_carry=0.
- Flags: computed from the same cycle's combinational result and stored with it. They never lag the result.
- Handshake:
  - Accept when i_valid & o_ready.
  - Deliver when o_valid & i_ready.
  - Upstream bundle is not held after acceptance; stage captures it.
  - Output bundle is stable while o_valid & !i_ready.
- Latency: 1 cycle. Bundle accepted at edge k appears with o_valid=1 after edge k when the output register was free or draining.
- Throughput: 1/cycle with i_ready held high.
- Storage: output register OUT, skid register SKID.
- FSM states:
  - EMPTY: OUT and SKID invalid.
  - ONE: OUT valid.
  - TWO: OUT and SKID valid.
- FSM transitions:
  - EMPTY: accept -> ONE (load OUT).
  - ONE: accept & !deliver -> TWO (load SKID).
  - ONE: accept & deliver -> ONE (reload OUT).
  - ONE: deliver & !accept -> EMPTY.
  - ONE: neither -> hold.
  - TWO: deliver -> ONE (OUT<=SKID).
  - TWO: no deliver -> hold.
  - TWO: accept cannot occur.
- o_ready = (state != TWO), registered; it never combinationally depends on i_ready.
- o_valid = (state != EMPTY).
- Ordering: strict FIFO; bundles never dropped or duplicated.
- Reset (any time, including mid-transfer or with TWO full):
  - State -> EMPTY.
  - o_valid=0, o_ready=1.
  - o_result=0 and o_carry, o_zero, o_negative, o_overflow all 0.
  - In-flight bundles discarded.
- i_valid while o_ready=0: ignored; upstream must hold.
- X on i_a/i_b when i_valid=0 must not propagate into state.

Optional Feature:
- Macro: ALU_EXEC_OVERFLOW_EN.
- Defined:
  - ADD overflow = (a[N-1]==b[N-1]) & (r[N-1]!=a[N-1]).
  - SUB overflow = (a[N-1]!=b[N-1]) & (r[N-1]!=a[N-1]).
  - AND/OR overflow = 0.
  - Overflow is stored per bundle through OUT/SKID.
- Undefined: o_overflow tied 0; no overflow storage bit.

Decomposition:
- Shared package alu_pkg:
  - typedef enum logic [1:0] alu_op_e {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR}.
  - typedef enum logic [1:0] exec_state_e {ST_EMPTY, ST_ONE, ST_TWO}.
  - Flags struct alu_flags_t {carry, zero, negative, overflow}.
- Sub-module alu_flags:
  - Purely combinational.
  - Takes a, b, result, carry, op.
  - Produces alu_flags_t.
- Stage instantiates the existing ALU datapath for result/carry.

Test Plan:
- N=8, ADD 0xFF+0x01, i_ready=1 -> next cycle o_result=0x00, carry=1, zero=1, negative=0, overflow=0.
- N=8, SUB 0x80-0x01 -> o_result=0x7F, carry=1, zero=0; overflow=1 with ALU_EXEC_OVERFLOW_EN, 0 without.
- N=8, back-to-back AND 0xF0&0x3C then OR 0xF0|0x0C, i_ready=1 -> consecutive cycles 0x30 (carry=0) and 0xFC (negative=1); o_ready stays 1.
- Backpressure: i_ready=0, present 3 bundles (ADD 1+2, ADD 3+4, ADD 5+6) -> two accepted, o_ready=0 after second. Raise i_ready -> outputs 3, 7, then 11 accepted and output, in order.
- N=64, SUB 0x0-0x1 -> o_result=0xFFFF_FFFF_FFFF_FFFF, carry=0 (borrow), negative=1.
- Assert i_rst asynchronously while state TWO -> immediately o_valid=0, o_ready=1, all outputs 0. After release, a new ADD 2+2 yields 4 with no stale bundles.
